control_subcmd_fillpattern: RTL and testbench

- Parametrised successor to the solid-fill subcommand engine. Sits under the command controller and drives the framebuffer write port one byte per cycle.
- Fills a clipped rectangle in one of three modes: solid, checkerboard or outline.
- Honours write-port backpressure.
- Uses the same done/ack handoff as the other subcommands.

---
 rtl/control_subcmd_fillpattern_pkg.sv | 36 +++
 rtl/control_subcmd_fillpattern_addr_walker.sv | 68 ++++++
 rtl/control_subcmd_fillpattern.sv | 154 +++++++++++++++
 tb/tb_control_subcmd_fillpattern.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_subcmd_fillpattern_pkg.sv
// Shared types for the fill-pattern subcommand: panel geometry defaults, address/colour
// types, mode and state enums, and the byte-lane colour selector.
package control_subcmd_fillpattern_pkg;

   localparam int P_BYTES_PER_PIXEL = 3;
   localparam int P_PIXEL_WIDTH     = 12;
   localparam int P_PIXEL_HEIGHT    = 10;

   localparam int COL_W = $clog2(P_PIXEL_WIDTH);
   localparam int ROW_W = $clog2(P_PIXEL_HEIGHT);
   localparam int PIX_W = (P_BYTES_PER_PIXEL > 1) ? $clog2(P_BYTES_PER_PIXEL) : 1;

   typedef logic [COL_W-1:0]               col_addr_t;
   typedef logic [ROW_W-1:0]               row_addr_t;
   typedef logic [PIX_W-1:0]               pixel_addr_t;
   typedef logic [P_BYTES_PER_PIXEL*8-1:0] color_t;
   typedef logic [7:0]                     mem_write_data_t;

   typedef enum logic [1:0] {FILL_SOLID, FILL_CHECKER, FILL_OUTLINE, FILL_RSVD} fillpat_mode_t;
   typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} fillpat_state_t;

   // Checker parity uses absolute panel coordinates so adjacent fills tile seamlessly.
   function automatic mem_write_data_t fill_byte(input fillpat_mode_t m, input color_t c,
                                                 input color_t c_alt, input row_addr_t r,
                                                 input col_addr_t col, input pixel_addr_t p,
                                                 input int cell_log2);
      row_addr_t r_cell;
      col_addr_t c_cell;
      color_t    sel;
      r_cell = r >> cell_log2;
      c_cell = col >> cell_log2;
      sel    = (m == FILL_CHECKER && (r_cell[0] ^ c_cell[0])) ? c_alt : c;
      return mem_write_data_t'(sel >> (8 * p));
   endfunction

endpackage

// File: rtl/control_subcmd_fillpattern_addr_walker.sv
// Descending row/column/byte-lane walker for the fill engine; nxt_* is the address that
// takes effect at the next clock edge.
module fillpattern_addr_walker
   import control_subcmd_fillpattern_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = P_BYTES_PER_PIXEL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic        skip,
   input  row_addr_t   load_row,
   input  col_addr_t   load_column,
   input  row_addr_t   row_lo,
   input  col_addr_t   col_lo,
   input  col_addr_t   col_hi,
   output row_addr_t   row,
   output col_addr_t   column,
   output pixel_addr_t pixel,
   output row_addr_t   nxt_row,
   output col_addr_t   nxt_column,
   output pixel_addr_t nxt_pixel,
   output logic        last
);

   localparam pixel_addr_t PIX_TOP = pixel_addr_t'(BYTES_PER_PIXEL - 1);

   always_comb begin
      // NOTE: defaults first keep every path assigned, so no latch is inferred.
      nxt_row    = row;
      nxt_column = column;
      nxt_pixel  = pixel;
      if (load) begin
         nxt_row    = load_row;
         nxt_column = load_column;
         nxt_pixel  = PIX_TOP;
      end else if (step) begin
         if (pixel != '0) begin
            nxt_pixel = pixel - 1'b1;
         end else begin
            nxt_pixel = PIX_TOP;
            if (column != col_lo) begin
               nxt_column = skip ? col_lo : column - 1'b1;
            end else begin
               nxt_column = col_hi;
               nxt_row    = row - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      if (reset) begin
         row    <= '0;
         column <= '0;
         pixel  <= '0;
      end else begin
         row    <= nxt_row;
         column <= nxt_column;
         pixel  <= nxt_pixel;
      end
   end

   assign last = (row == row_lo) && (column == col_lo) && (pixel == '0);

endmodule

// File: rtl/control_subcmd_fillpattern.sv
// Fill-pattern subcommand: solid/checker/outline fill of a clipped rectangle, one byte per
// cycle with backpressure. Optional counters under CONTROL_SUBCMD_FILLPATTERN_STATS_EN.
module control_subcmd_fillpattern
   import control_subcmd_fillpattern_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = P_BYTES_PER_PIXEL,
   parameter int PIXEL_WIDTH     = P_PIXEL_WIDTH,
   parameter int PIXEL_HEIGHT    = P_PIXEL_HEIGHT,
   parameter int CHECKER_LOG2    = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            ack,
   input  logic            ram_ready,
   input  fillpat_mode_t   mode,
   input  col_addr_t       x1,
   input  row_addr_t       y1,
   input  col_addr_t       width,
   input  row_addr_t       height,
   input  color_t          color,
   input  color_t          color_alt,
   output row_addr_t       row,
   output col_addr_t       column,
   output pixel_addr_t     pixel,
   output mem_write_data_t data_out,
   output logic            ram_write_enable,
   output logic            ram_access_start,
   output logic            done
`ifdef CONTROL_SUBCMD_FILLPATTERN_STATS_EN
 , output logic [31:0]     write_count,
   output logic [31:0]     stall_count
`endif
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SETUP = SETUP;
   localparam logic [1:0] S_WRITE = WRITE;
   localparam logic [1:0] S_DONE  = DONE;

   localparam logic [COL_W:0] PW = (COL_W + 1)'(PIXEL_WIDTH);
   localparam logic [ROW_W:0] PH = (ROW_W + 1)'(PIXEL_HEIGHT);

   logic [1:0]      state;
   fillpat_mode_t   mode_q;
   color_t          color_q, color_alt_q;
   col_addr_t       x1_q, col_hi_q, start_col, nxt_column;
   row_addr_t       y1_q, row_hi_q, start_row, nxt_row;
   pixel_addr_t     nxt_pixel;
   logic [COL_W:0]  xe_sum, xe_clip;
   logic [ROW_W:0]  ye_sum, ye_clip;
   logic            area_empty, load, strobe, step, finish, skip, last;
   mem_write_data_t byte_next;

   // Bounds are summed one bit wider than the operands so x1+width cannot wrap.
   always_comb begin
      xe_sum     = {1'b0, x1} + {1'b0, width};
      ye_sum     = {1'b0, y1} + {1'b0, height};
      xe_clip    = (xe_sum > PW) ? PW : xe_sum;
      ye_clip    = (ye_sum > PH) ? PH : ye_sum;
      start_col  = col_addr_t'(xe_clip - 1'b1);
      start_row  = row_addr_t'(ye_clip - 1'b1);
      area_empty = (width == '0) || (height == '0) || ({1'b0, x1} >= PW) || ({1'b0, y1} >= PH);
   end

   assign load   = (state == S_SETUP) && enable && !area_empty;
   assign strobe = (state == S_WRITE) && enable && ram_ready && !reset;
   assign step   = strobe && !last;
   assign finish = strobe && last;
   assign skip   = (mode_q == FILL_OUTLINE) && (row != y1_q) && (row != row_hi_q);

   fillpattern_addr_walker #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_walker (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .skip       (skip),
      .load_row   (start_row),
      .load_column(start_col),
      .row_lo     (y1_q),
      .col_lo     (x1_q),
      .col_hi     (col_hi_q),
      .row        (row),
      .column     (column),
      .pixel      (pixel),
      .nxt_row    (nxt_row),
      .nxt_column (nxt_column),
      .nxt_pixel  (nxt_pixel),
      .last       (last)
   );

   // The first byte is formed from the live inputs because the operand registers load
   // on the same edge.
   assign byte_next = load
      ? fill_byte(mode, color, color_alt, nxt_row, nxt_column, nxt_pixel, CHECKER_LOG2)
      : fill_byte(mode_q, color_q, color_alt_q, nxt_row, nxt_column, nxt_pixel, CHECKER_LOG2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         ram_access_start <= 1'b0;
         data_out         <= '0;
         mode_q           <= FILL_SOLID;
         color_q          <= '0;
         color_alt_q      <= '0;
         x1_q             <= '0;
         y1_q             <= '0;
         col_hi_q         <= '0;
         row_hi_q         <= '0;
      end else begin
         ram_access_start <= load;
         if (load || step) data_out <= byte_next;
         case (state)
            S_IDLE:  if (enable) state <= S_SETUP;
            S_SETUP: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else begin
                  mode_q      <= mode;
                  color_q     <= color;
                  color_alt_q <= color_alt;
                  x1_q        <= x1;
                  y1_q        <= y1;
                  col_hi_q    <= start_col;
                  row_hi_q    <= start_row;
                  state       <= area_empty ? S_DONE : S_WRITE;
               end
            end
            S_WRITE: begin
               if (!enable)     state <= S_IDLE;
               else if (finish) state <= S_DONE;
            end
            S_DONE:  if (ack) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ram_write_enable = strobe;
   assign done             = (state == S_DONE);

`ifdef CONTROL_SUBCMD_FILLPATTERN_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || state == S_SETUP) begin
         write_count <= '0;
         stall_count <= '0;
      end else if (state == S_WRITE) begin
         if (strobe)     write_count <= write_count + 32'd1;
         if (!ram_ready) stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_control_subcmd_fillpattern.sv
// Directed bench for control_subcmd_fillpattern: a queue model built from the fill rules
// is checked against every strobe, plus literal pins on counts, latency and pattern bytes.
module tb_control_subcmd_fillpattern;
   import control_subcmd_fillpattern_pkg::*;

   localparam int W = P_PIXEL_WIDTH;
   localparam int H = P_PIXEL_HEIGHT;
   localparam int B = P_BYTES_PER_PIXEL;
   localparam int CELL_LOG2 = 0;

   logic            clk = 1'b0;
   logic            reset, enable, ack, ram_ready;
   fillpat_mode_t   mode;
   col_addr_t       x1, width;
   row_addr_t       y1, height;
   color_t          color, color_alt;
   row_addr_t       row;
   col_addr_t       column;
   pixel_addr_t     pixel;
   mem_write_data_t data_out;
   logic            ram_write_enable, ram_access_start, done;
`ifdef CONTROL_SUBCMD_FILLPATTERN_STATS_EN
   logic [31:0]     write_count, stall_count;
`endif

   control_subcmd_fillpattern #(.CHECKER_LOG2(CELL_LOG2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ack(ack), .ram_ready(ram_ready),
      .mode(mode), .x1(x1), .y1(y1), .width(width), .height(height),
      .color(color), .color_alt(color_alt), .row(row), .column(column), .pixel(pixel),
      .data_out(data_out), .ram_write_enable(ram_write_enable),
      .ram_access_start(ram_access_start), .done(done)
`ifdef CONTROL_SUBCMD_FILLPATTERN_STATS_EN
    , .write_count(write_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int        row;
      int        col;
      int        pix;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0, errors = 0;
   int         strobe_cnt, start_cnt, stall_exp;
   bit         wr_phase = 1'b0, abort_mode = 1'b0, prev_stall = 1'b0;
   logic [9:0] prev_addr;
   logic [7:0] fb   [H][W][B];
   bit         seen [H][W][B];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Expected strobe order: rows top-down from ye-1, columns from xe-1, lanes from B-1.
   task automatic build_model(input fillpat_mode_t m, input int x1v, input int y1v,
                              input int wv, input int hv, input color_t c, input color_t ca);
      int xe, ye;
      color_t sel;
      exp_t e;
      xe = (x1v + wv > W) ? W : x1v + wv;
      ye = (y1v + hv > H) ? H : y1v + hv;
      exp_q.delete();
      for (int r = ye - 1; r >= y1v; r--) begin
         for (int cc = xe - 1; cc >= x1v; cc--) begin
            if (m == FILL_OUTLINE && r != y1v && r != ye - 1 && cc != x1v && cc != xe - 1)
               continue;
            sel = (m == FILL_CHECKER && (((r >> CELL_LOG2) ^ (cc >> CELL_LOG2)) & 1) == 1) ? ca : c;
            for (int p = B - 1; p >= 0; p--) begin
               e.row = r; e.col = cc; e.pix = p; e.data = 8'(sel >> (8 * p));
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic clear_fb();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            for (int p = 0; p < B; p++) begin
               fb[r][c][p] = 8'h00;
               seen[r][c][p] = 1'b0;
            end
      strobe_cnt = 0;
      start_cnt  = 0;
      stall_exp  = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ram_access_start) begin
         start_cnt++;
         wr_phase = 1'b1;
      end
      if (done || abort_mode) wr_phase = 1'b0;
      if (prev_stall) check("frozen_addr", {row, column, pixel}, prev_addr);
      prev_stall = wr_phase && !done && !ram_ready;
      prev_addr  = {row, column, pixel};
      if (wr_phase && !ram_ready) stall_exp++;
      if (abort_mode) begin
         check("strobe_after_abort", ram_write_enable, 1'b0);
         check("done_after_abort", done, 1'b0);
      end else if (ram_write_enable) begin
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            check("strobe_unexpected", ram_write_enable, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_row_col_pix_data", {row, column, pixel, data_out},
                  {row_addr_t'(e.row), col_addr_t'(e.col), pixel_addr_t'(e.pix), e.data});
         end
         if (int'(row) < H && int'(column) < W && int'(pixel) < B) begin
            check("dup_write", seen[row][column][pixel], 1'b0);
            seen[row][column][pixel] = 1'b1;
            fb[row][column][pixel]   = data_out;
         end
      end
   end

   task automatic run_fill(input string tag, input fillpat_mode_t m, input int x1v, input int y1v,
                           input int wv, input int hv, input color_t c, input color_t ca,
                           input bit bp, input int n_exp);
      int cyc;
      bit got;
      logic [3:0] bp_pat;
      bp_pat = 4'b1001;
      build_model(m, x1v, y1v, wv, hv, c, ca);
      check({tag, "_model_size"}, exp_q.size(), n_exp);
      clear_fb();
      @(posedge clk); #1;
      mode = m; x1 = col_addr_t'(x1v); y1 = row_addr_t'(y1v);
      width = col_addr_t'(wv); height = row_addr_t'(hv);
      color = c; color_alt = ca; ram_ready = 1'b1; enable = 1'b1;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
         if (done) got = 1'b1;
         else if (bp) ram_ready = bp_pat[cyc % 4] ^ ($urandom_range(0, 4) == 0);
      end
      check({tag, "_done_seen"}, got, 1'b1);
      if (!bp) check({tag, "_latency"}, cyc, n_exp + 2);
      check({tag, "_strobes"}, strobe_cnt, n_exp);
      check({tag, "_start_pulses"}, start_cnt, (n_exp > 0) ? 1 : 0);
      check({tag, "_model_drained"}, exp_q.size(), 0);
`ifdef CONTROL_SUBCMD_FILLPATTERN_STATS_EN
      check({tag, "_write_count"}, write_count, n_exp);
      check({tag, "_stall_count"}, stall_count, stall_exp);
`endif
      enable = 1'b0; ram_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check({tag, "_done_held"}, done, 1'b1);
      end
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check({tag, "_done_cleared"}, done, 1'b0);
   endtask

   task automatic run_abort(input string tag, input bit use_reset);
      int cyc;
      build_model(FILL_SOLID, 0, 0, W, H, 24'h5A5A5A, 24'h0);
      clear_fb();
      @(posedge clk); #1;
      mode = FILL_SOLID; x1 = '0; y1 = '0;
      width = col_addr_t'(W); height = row_addr_t'(H);
      color = 24'h5A5A5A; ram_ready = 1'b1; enable = 1'b1;
      cyc = 0;
      while (strobe_cnt < 20 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_reached_write"}, strobe_cnt >= 20, 1'b1);
      exp_q.delete();
      abort_mode = 1'b1;
      if (use_reset) reset = 1'b1;
      else enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; enable = 1'b0;
      if (use_reset)
         check({tag, "_reset_outputs"},
               {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, '0);
      repeat (6) @(posedge clk);
      #1;
      abort_mode = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; ack = 1'b0; ram_ready = 1'b0; mode = FILL_SOLID;
      x1 = '0; y1 = '0; width = '0; height = '0; color = '0; color_alt = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, '0);
      reset = 1'b0;

      run_fill("solid_full", FILL_SOLID, 0, 0, W, H, 24'hA5A5A5, 24'h000000, 1'b0, W * H * B);
      check("solid_first_byte", fb[H-1][W-1][B-1], 8'hA5);
      check("solid_last_byte", fb[0][0][0], 8'hA5);

      run_fill("checker", FILL_CHECKER, 0, 0, 4, 4, 24'h000000, 24'hFFFFFF, 1'b0, 48);
      check("checker_x1_y0", fb[0][1][0], 8'hFF);
      check("checker_x1_y1", fb[1][1][0], 8'h00);

      run_fill("outline", FILL_OUTLINE, 2, 1, 5, 4, 24'h336699, 24'hFFFFFF, 1'b0, 42);
      for (int r = 2; r <= 3; r++)
         for (int c = 3; c <= 5; c++)
            check("outline_interior", seen[r][c][0], 1'b0);

      run_fill("outline_row", FILL_OUTLINE, 1, 7, 4, 1, 24'h010203, 24'h0, 1'b0, 12);
      run_fill("outline_col", FILL_OUTLINE, 5, 3, 1, 4, 24'h040506, 24'h0, 1'b0, 12);
      run_fill("clip_right", FILL_SOLID, W - 2, 4, 10, 1, 24'h778899, 24'h0, 1'b0, 6);
      run_fill("clip_both", FILL_SOLID, 9, 8, 15, 15, 24'h13579B, 24'h0, 1'b0, 18);
      run_fill("empty_x1", FILL_SOLID, W, 0, 3, 3, 24'hFFFFFF, 24'h0, 1'b0, 0);
      run_fill("reserved", FILL_RSVD, 0, 9, 3, 1, 24'hC0FFEE, 24'h111111, 1'b0, 9);
      run_fill("chk_nostall", FILL_CHECKER, 3, 2, 6, 5, 24'h123456, 24'hABCDEF, 1'b0, 90);
      run_fill("chk_stall", FILL_CHECKER, 3, 2, 6, 5, 24'h123456, 24'hABCDEF, 1'b1, 90);

      run_abort("abort_reset", 1'b1);
      run_abort("abort_enable", 1'b0);
      run_fill("after_abort", FILL_SOLID, 4, 4, 3, 2, 24'h2468AC, 24'h0, 1'b0, 18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
